sysarr_feed_ctrl: RTL and testbench

Upstream controller for the systolic-array row FIFOs. Accepts one N×N operand tile row-by-row over a valid/ready handshake and loads row r into FIFO r. It then drives the per-FIFO shift strobes with a one-cycle diagonal skew, so that element streams enter the array staggered. It sits between the operand buffer and the bank of N row FIFOs.

---
 rtl/sysarr_pkg.sv | 26 ++
 rtl/sysarr_skew_gen.sv | 41 ++++
 rtl/sysarr_feed_ctrl.sv | 127 ++++++++++++
 tb/tb_sysarr_feed_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sysarr_pkg                                             |
// | Description : Shared types and default sizes for the systolic-array  |
// |               operand feed path.                                     |
// | Contents    : SYSARR_N / SYSARR_WIDTH default dimensions,            |
// |               feed_state_t controller state enum, row_t row vector.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sysarr_pkg;

  localparam int SYSARR_N     = 4;
  localparam int SYSARR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } feed_state_t;

  typedef logic [SYSARR_WIDTH*SYSARR_N-1:0] row_t;

endpackage

`default_nettype wire

// File: rtl/sysarr_skew_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sysarr_skew_gen                                        |
// | Description : Diagonal shift-strobe generator. FIFO i shifts while   |
// |               the stream count lies in the window [i, i+N).          |
// | Ports       : s_cnt      in  stream cycle count                      |
// |               enable     in  streaming and not stalled               |
// |               fifo_shift out per-FIFO shift strobe                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sysarr_skew_gen
  import sysarr_pkg::*;
#(
  parameter int N = SYSARR_N
) (
  input  logic [$clog2(2*N)-1:0] s_cnt,
  input  logic                   enable,
  output logic [N-1:0]           fifo_shift
);

  localparam int SW = $clog2(2*N);

  // One spare bit so i+N is representable for every lane.
  logic [SW:0] w_cnt_ext;
  assign w_cnt_ext = {1'b0, s_cnt};

  for (genvar i = 0; i < N; i++) begin : g_shift
    localparam logic [SW:0] C_HI = (SW+1)'(i + N);
    if (i == 0) begin : g_first
      // Lower bound of lane 0 is always met.
      assign fifo_shift[i] = enable && (w_cnt_ext < C_HI);
    end else begin : g_rest
      localparam logic [SW:0] C_LO = (SW+1)'(i);
      assign fifo_shift[i] = enable && (w_cnt_ext >= C_LO) && (w_cnt_ext < C_HI);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sysarr_feed_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sysarr_feed_ctrl                                       |
// | Description : Loads one NxN operand tile row-by-row into N row FIFOs |
// |               and then streams them with a one-cycle diagonal skew.  |
// | Ports       : clk, nRST (async, active-low)                          |
// |               in_valid/in_ready/in_row   upstream row handshake      |
// |               stall                      array back-pressure         |
// |               fifo_load/fifo_load_values one-hot FIFO load + data    |
// |               fifo_shift                 per-FIFO shift strobes      |
// |               busy, done                 status / end-of-tile pulse  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sysarr_feed_ctrl
  import sysarr_pkg::*;
#(
  parameter int N     = SYSARR_N,
  parameter int WIDTH = SYSARR_WIDTH
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH*N-1:0] in_row,
  input  logic               stall,
  output logic [N-1:0]       fifo_load,
  output logic [WIDTH*N-1:0] fifo_load_values,
  output logic [N-1:0]       fifo_shift,
  output logic               busy,
  output logic               done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2*N);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(N - 1);
  localparam logic [SW-1:0] C_LAST_S   = SW'(2*N - 2);

  feed_state_t    r_state,   w_state_nxt;
  logic [RW-1:0]  r_row_cnt, w_row_cnt_nxt;
  logic [SW-1:0]  r_s_cnt,   w_s_cnt_nxt;
  logic           w_shift_en;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_row_cnt <= '0;
      r_s_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_s_cnt   <= w_s_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_s_cnt_nxt   = r_s_cnt;
    in_ready      = 1'b0;
    fifo_load     = '0;
    w_shift_en    = 1'b0;
    done          = 1'b0;

    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fifo_load[0] = 1'b1;
          if (N == 1) begin
            // A single-row tile is complete after its first handshake.
            w_state_nxt = STREAM;
            w_s_cnt_nxt = '0;
          end else begin
            w_row_cnt_nxt = RW'(1);
            w_state_nxt   = LOAD;
          end
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fifo_load[r_row_cnt] = 1'b1;
          if (r_row_cnt == C_LAST_ROW) begin
            w_state_nxt = STREAM;
            w_s_cnt_nxt = '0;
          end else begin
            w_row_cnt_nxt = r_row_cnt + RW'(1);
          end
        end
      end

      STREAM: begin
        // A stalled cycle freezes the whole skew window, including done.
        if (!stall) begin
          w_shift_en = 1'b1;
          if (r_s_cnt == C_LAST_S) begin
            done          = 1'b1;
            w_state_nxt   = IDLE;
            w_row_cnt_nxt = '0;
            w_s_cnt_nxt   = '0;
          end else begin
            w_s_cnt_nxt = r_s_cnt + SW'(1);
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  sysarr_skew_gen #(
    .N (N)
  ) u_skew (
    .s_cnt      (r_s_cnt),
    .enable     (w_shift_en),
    .fifo_shift (fifo_shift)
  );

  // FIFOs decide element ordering; the row is forwarded untouched.
  assign fifo_load_values = in_row;
  assign busy             = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sysarr_feed_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_sysarr_feed_ctrl                                    |
// | Description : Self-checking bench for sysarr_feed_ctrl (N=4, W=16):  |
// |               directed vector table, reset-mid-stream sequence and a |
// |               randomized run against a tile-timeline model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sysarr_feed_ctrl;
  import sysarr_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          in_valid = 1'b0;
  logic          stall = 1'b0;
  row_t          in_row = '0;
  logic          in_ready, busy, done;
  logic [N-1:0]  fifo_load, fifo_shift;
  row_t          fifo_load_values;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sysarr_feed_ctrl #(.N(N), .WIDTH(W)) dut (
    .clk              (clk),
    .nRST             (nRST),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_row           (in_row),
    .stall            (stall),
    .fifo_load        (fifo_load),
    .fifo_load_values (fifo_load_values),
    .fifo_shift       (fifo_shift),
    .busy             (busy),
    .done             (done)
  );

  typedef struct {
    logic       valid;
    logic       stl;
    row_t       row;
    logic       exp_ready;
    logic [3:0] exp_load;
    logic [3:0] exp_shift;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic s, row_t r, logic rdy,
                              logic [3:0] ld, logic [3:0] sh, logic b, logic d);
    vec_t x;
    x.valid = v; x.stl = s; x.row = r; x.exp_ready = rdy;
    x.exp_load = ld; x.exp_shift = sh; x.exp_busy = b; x.exp_done = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic [3:0] ld,
                            input logic [3:0] sh, input logic b, input logic d, input row_t r);
    chk({tag, ".in_ready"},   64'(in_ready),   64'(rdy));
    chk({tag, ".fifo_load"},  64'(fifo_load),  64'(ld));
    chk({tag, ".fifo_shift"}, 64'(fifo_shift), 64'(sh));
    chk({tag, ".busy"},       64'(busy),       64'(b));
    chk({tag, ".done"},       64'(done),       64'(d));
    if (ld != 4'b0) chk({tag, ".load_values"}, fifo_load_values, r);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
  task automatic drive(input logic v, input logic s, input row_t r);
    @(posedge clk);
    #1;
    in_valid = v; stall = s; in_row = r;
    #4;
  endtask

  localparam row_t R0 = 64'h0001_0002_0003_0004;
  localparam row_t R1 = 64'h0005_0006_0007_0008;
  localparam row_t R2 = 64'h0009_000A_000B_000C;
  localparam row_t R3 = 64'h000D_000E_000F_0010;
  localparam row_t RX = 64'hDEAD_BEEF_CAFE_F00D;

  // Model state for the random run: rows held by the FIFOs and unstalled
  // stream cycles elapsed since the last row was accepted.
  int   m_loaded;
  int   m_k;

  initial begin
    // Back-to-back load, valid held during STREAM, clean skew, stall in IDLE.
    tbl.push_back(mk(1,0,R0,1,4'b0001,4'b0000,0,0));
    tbl.push_back(mk(1,0,R1,1,4'b0010,4'b0000,1,0));
    tbl.push_back(mk(1,0,R2,1,4'b0100,4'b0000,1,0));
    tbl.push_back(mk(1,0,R3,1,4'b1000,4'b0000,1,0));
    tbl.push_back(mk(1,0,RX,0,4'b0000,4'b0001,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b0011,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b0111,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1111,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1110,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1100,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1000,1,1));
    tbl.push_back(mk(0,1,'0,1,4'b0000,4'b0000,0,0));
    // Gapped valid, stall during LOAD, 2-cycle stall at 0111, stall on done.
    tbl.push_back(mk(1,0,R0,1,4'b0001,4'b0000,0,0));
    tbl.push_back(mk(1,0,R1,1,4'b0010,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,1,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,1,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,1,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(1,0,R2,1,4'b0100,4'b0000,1,0));
    tbl.push_back(mk(1,1,R3,1,4'b1000,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b0001,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b0011,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b0111,1,0));
    tbl.push_back(mk(0,1,'0,0,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(0,1,'0,0,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1111,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1110,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1100,1,0));
    tbl.push_back(mk(0,1,'0,0,4'b0000,4'b0000,1,0));
    tbl.push_back(mk(0,0,'0,0,4'b0000,4'b1000,1,1));
    tbl.push_back(mk(0,0,'0,1,4'b0000,4'b0000,0,0));

    // Reset state.
    #12;
    check_outs("reset", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    @(posedge clk); #1; nRST = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].stl, tbl[i].row);
      check_outs($sformatf("vec[%0d]", i), tbl[i].exp_ready, tbl[i].exp_load,
                 tbl[i].exp_shift, tbl[i].exp_busy, tbl[i].exp_done, tbl[i].row);
    end

    // Reset asserted while the stream count is at 3.
    begin
      row_t rows [4];
      logic [3:0] skew [3];
      rows[0] = R0; rows[1] = R1; rows[2] = R2; rows[3] = R3;
      skew[0] = 4'b0001; skew[1] = 4'b0011; skew[2] = 4'b0111;
      for (int r = 0; r < 4; r++) begin
        drive(1'b1, 1'b0, rows[r]);
        check_outs($sformatf("rst_seq.load%0d", r), 1'b1, 4'(1 << r), 4'b0000,
                   (r != 0), 1'b0, rows[r]);
      end
      for (int s = 0; s < 3; s++) begin
        drive(1'b0, 1'b0, '0);
        check_outs($sformatf("rst_seq.skew%0d", s), 1'b0, 4'b0000, skew[s], 1'b1, 1'b0, '0);
      end
      @(posedge clk); #1;
      nRST = 1'b0;
      #4;
      check_outs("rst_seq.in_reset", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      nRST = 1'b1; in_valid = 1'b1; in_row = R2;
      #4;
      check_outs("rst_seq.reload", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, R2);
      drive(1'b0, 1'b0, '0);
      check_outs("rst_seq.hold", 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
    end

    // Fresh start for the randomized run.
    @(posedge clk); #1; nRST = 1'b0; in_valid = 1'b0; stall = 1'b0;
    @(posedge clk); #1; nRST = 1'b1;
    m_loaded = 0;
    m_k      = 0;

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 199) == 0) begin
        nRST = 1'b0; in_valid = 1'b0; stall = 1'($urandom);
        #4;
        check_outs($sformatf("rnd[%0d].reset", c), 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        m_loaded = 0;
        m_k      = 0;
      end else begin
        logic       e_rdy, e_done, hs, streaming;
        logic [3:0] e_ld, e_sh;
        nRST     = 1'b1;
        in_valid = ($urandom_range(0, 9) < 7);
        stall    = ($urandom_range(0, 3) == 0);
        in_row   = {$urandom, $urandom};
        #4;
        streaming = (m_loaded == N);
        e_rdy     = !streaming;
        hs        = in_valid && e_rdy;
        e_ld      = hs ? 4'(1 << m_loaded) : 4'b0000;
        for (int i = 0; i < N; i++)
          e_sh[i] = streaming && !stall && (m_k >= i) && (m_k < i + N);
        e_done = streaming && !stall && (m_k == 2*N - 2);
        check_outs($sformatf("rnd[%0d]", c), e_rdy, e_ld, e_sh, (m_loaded > 0), e_done, in_row);
        if (hs) begin
          m_loaded++;
        end else if (streaming && !stall) begin
          if (e_done) begin
            m_loaded = 0;
            m_k      = 0;
          end else begin
            m_k++;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
